rggen_bus_responder: RTL and testbench

RGGEN_BUS_RESPONDER -- requirements
Module: rggen_bus_responder

---
 rtl/rggen_bus_responder_if.sv | 49 ++++
 rtl/rggen_bus_responder.sv | 146 ++++++++++++++
 tb/tb_rggen_bus_responder.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_bus_responder_if.sv
// Shared bus types and the initiator/responder bus interface.
// Package rggen_rtl_pkg: rggen_direction, rggen_status.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'd0,
    RGGEN_EXOKAY       = 2'd1,
    RGGEN_SLAVE_ERROR  = 2'd2,
    RGGEN_DECODE_ERROR = 2'd3
  } rggen_status;

endpackage

// Bus bundle: request/address/direction/write_data/write_strobe from
// the initiator; done/status/read_data back from the responder.
interface rggen_bus_if
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);

  logic                      request;
  logic [ADDRESS_WIDTH-1:0]  address;
  rggen_direction            direction;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH/8-1:0]   write_strobe;
  logic                      done;
  rggen_status               status;
  logic [DATA_WIDTH-1:0]     read_data;

  modport master (
    output request, address, direction,
    output write_data, write_strobe,
    input  done, status, read_data
  );

  modport slave (
    input  request, address, direction,
    input  write_data, write_strobe,
    output done, status, read_data
  );

endinterface

// File: rtl/rggen_bus_responder.sv
// Bus responder: WORDS x DATA_WIDTH storage behind an rggen bus with
// LATENCY wait cycles and a one-cycle done pulse per access.
// Ports: clk, rst (async, active-high), bus_if (rggen_bus_if.slave).
// Macro RGGEN_BUS_RESPONDER_ERROR_EN: out-of-range index -> SLAVE_ERROR;
// without it the index wraps modulo WORDS.
module rggen_bus_responder
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int WORDS         = 16,
  parameter int LATENCY       = 1,
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
  input logic        clk,
  input logic        rst,
  rggen_bus_if.slave bus_if
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int IDX_W  = ADDRESS_WIDTH - LSB;
  localparam int WIDX   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0] CNT_LOAD =
    4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   blk_q, blk_d;
  logic                   cap;

  logic [IDX_W-1:0]       idx_q;
  rggen_direction         dir_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [STRB_W-1:0]      wstrb_q;

  logic [DATA_WIDTH-1:0]  mem_q [WORDS];

  logic [31:0]            idx_ext;
  logic [WIDX-1:0]        word_idx;
  logic                   err;
  logic                   respond;
  logic                   wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

  // blk_q marks the IDLE cycle right after RESPOND, where a held
  // request is deliberately not accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus_if.request && !blk_q) begin
          cap = 1'b1;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RESPOND;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPOND: begin
        state_d = IDLE;
        blk_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      dir_q   <= RGGEN_READ;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (cap) begin
      idx_q   <= bus_if.address[ADDRESS_WIDTH-1:LSB];
      dir_q   <= bus_if.direction;
      wdata_q <= bus_if.write_data;
      wstrb_q <= bus_if.write_strobe;
    end
  end

  assign idx_ext  = 32'(idx_q);
  assign word_idx = WIDX'(idx_ext % WORDS);

`ifdef RGGEN_BUS_RESPONDER_ERROR_EN
  assign err = (idx_ext >= 32'(WORDS));
`else
  assign err = 1'b0;
`endif

  assign respond = (state_q == RESPOND);
  assign wr_en   = respond && (dir_q == RGGEN_WRITE) && !err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= INITIAL_VALUE;
      end
    end else if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus_if.done   = respond;
  assign bus_if.status = (respond && err) ? RGGEN_SLAVE_ERROR
                                          : RGGEN_OKAY;
  assign bus_if.read_data =
    (respond && (dir_q == RGGEN_READ) && !err) ? mem_q[word_idx]
                                               : '0;

endmodule

// File: tb/tb_rggen_bus_responder.sv
// Bench for rggen_bus_responder: three instances (LATENCY 0, 1, 3)
// share one stimulus bus; a scoreboard checks every done pulse.
module tb_rggen_bus_responder;
  import rggen_rtl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 req;
  logic [7:0]           addr;
  rggen_direction       dir;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic [2:0]           en;

  int LAT [3] = '{0, 1, 3};

  rggen_bus_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) b0 ();
  rggen_bus_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) b1 ();
  rggen_bus_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) b3 ();

  assign b0.request = req & en[0];
  assign b1.request = req & en[1];
  assign b3.request = req & en[2];
  assign b0.address = addr;
  assign b1.address = addr;
  assign b3.address = addr;
  assign b0.direction = dir;
  assign b1.direction = dir;
  assign b3.direction = dir;
  assign b0.write_data = wdata;
  assign b1.write_data = wdata;
  assign b3.write_data = wdata;
  assign b0.write_strobe = wstrb;
  assign b1.write_strobe = wstrb;
  assign b3.write_strobe = wstrb;

  rggen_bus_responder #(.LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .bus_if(b0)
  );
  rggen_bus_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .bus_if(b1)
  );
  rggen_bus_responder #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .bus_if(b3)
  );

  logic        done_w [3];
  rggen_status st_w   [3];
  logic [31:0] rd_w   [3];
  assign done_w[0] = b0.done;
  assign done_w[1] = b1.done;
  assign done_w[2] = b3.done;
  assign st_w[0] = b0.status;
  assign st_w[1] = b1.status;
  assign st_w[2] = b3.status;
  assign rd_w[0] = b0.read_data;
  assign rd_w[1] = b1.read_data;
  assign rd_w[2] = b3.read_data;

  typedef struct {
    int          inst;
    int          cyc;
    rggen_status st;
    logic [31:0] rd;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] mdl [3][16];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        prev_done [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) cyc = cyc + 1;

  int   mk;
  exp_t me;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_w[i]) begin
        mk = -1;
        foreach (sbq[j]) begin
          if (mk < 0 && sbq[j].inst == i) mk = j;
        end
        n_chk++;
        if (mk < 0) begin
          n_fail++;
          $display("FAIL unexpected_done inst=%0d cyc=%0d", i, cyc);
        end else begin
          me = sbq[mk];
          sbq.delete(mk);
          n_chk++;
          if (cyc !== me.cyc) begin
            n_fail++;
            $display("FAIL done_cycle inst=%0d got=%0d exp=%0d",
                     i, cyc, me.cyc);
          end
          n_chk++;
          if (st_w[i] !== me.st) begin
            n_fail++;
            $display("FAIL status inst=%0d got=%0d exp=%0d",
                     i, st_w[i], me.st);
          end
          n_chk++;
          if (rd_w[i] !== me.rd) begin
            n_fail++;
            $display("FAIL read_data inst=%0d got=%h exp=%h",
                     i, rd_w[i], me.rd);
          end
        end
        n_chk++;
        if (prev_done[i]) begin
          n_fail++;
          $display("FAIL done_width inst=%0d got=2 cycles exp=1", i);
        end
      end else begin
        n_chk++;
        if (rd_w[i] !== 32'h0 || st_w[i] !== RGGEN_OKAY) begin
          n_fail++;
          $display("FAIL idle_outputs inst=%0d got=%h/%0d exp=0/0",
                   i, rd_w[i], st_w[i]);
        end
      end
      prev_done[i] = done_w[i];
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 16; w++) mdl[i][w] = 32'h0;
  endtask

  // Push the expectation for instance i and update its model.
  task automatic push_exp(input int i, input int sample_cyc,
                          input rggen_direction d,
                          input logic [7:0] a,
                          input logic [31:0] wd,
                          input logic [3:0] ws);
    exp_t e;
    int   idx;
    bit   er;
    idx = int'(a) >> 2;
    er  = 1'b0;
`ifdef RGGEN_BUS_RESPONDER_ERROR_EN
    if (idx >= 16) er = 1'b1;
`endif
    idx = idx % 16;
    e.inst = i;
    e.cyc  = sample_cyc + LAT[i];
    e.st   = er ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
    e.rd   = (d == RGGEN_READ && !er) ? mdl[i][idx] : 32'h0;
    sbq.push_back(e);
    if (d == RGGEN_WRITE && !er)
      for (int b = 0; b < 4; b++)
        if (ws[b]) mdl[i][idx][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic issue(input rggen_direction d, input logic [7:0] a,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input logic [2:0] m);
    @(negedge clk);
    req = 1'b1; addr = a; dir = d;
    wdata = wd; wstrb = ws; en = m;
    for (int i = 0; i < 3; i++)
      if (m[i]) push_exp(i, cyc + 1, d, a, wd, ws);
    @(negedge clk);
    req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; addr = '0; dir = RGGEN_READ;
    wdata = '0; wstrb = '0; en = 3'b111;
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (done_w[i] !== 1'b0 || st_w[i] !== RGGEN_OKAY ||
          rd_w[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs inst=%0d got=%b/%0d/%h exp=0/0/0",
                 i, done_w[i], st_w[i], rd_w[i]);
      end
    end
    rst = 1'b0;
    issue(RGGEN_READ, 8'h04, 32'h0, 4'h0, 3'b111);
    issue(RGGEN_READ, 8'h3C, 32'h0, 4'h0, 3'b111);
  endtask

  task automatic test_write_read();
    issue(RGGEN_WRITE, 8'h04, 32'hDEAD_BEEF, 4'hF, 3'b111);
    issue(RGGEN_READ,  8'h04, 32'h0, 4'h0, 3'b111);
    issue(RGGEN_WRITE, 8'h3C, 32'h0BAD_F00D, 4'hF, 3'b111);
    issue(RGGEN_READ,  8'h3C, 32'h0, 4'h0, 3'b111);
  endtask

  task automatic test_strobe();
    issue(RGGEN_WRITE, 8'h00, 32'h1122_3344, 4'hF, 3'b111);
    issue(RGGEN_WRITE, 8'h00, 32'hAABB_CCDD, 4'h5, 3'b111);
    issue(RGGEN_READ,  8'h00, 32'h0, 4'h0, 3'b111);
    issue(RGGEN_WRITE, 8'h00, 32'hFFFF_FFFF, 4'h0, 3'b111);
    issue(RGGEN_READ,  8'h03, 32'h0, 4'h0, 3'b111);
    issue(RGGEN_WRITE, 8'h0A, 32'h5566_7788, 4'hA, 3'b111);
    issue(RGGEN_READ,  8'h09, 32'h0, 4'h0, 3'b111);
  endtask

  task automatic test_back_to_back();
    int n0;
    int pulses;
    @(negedge clk);
    req = 1'b1; addr = 8'h04; dir = RGGEN_READ;
    wdata = '0; wstrb = '0; en = 3'b001;
    n0 = cyc;
    for (int k = 0; k < 4; k++)
      push_exp(0, n0 + 1 + 3 * k, RGGEN_READ, 8'h04, 32'h0, 4'h0);
    pulses = 0;
    repeat (11) begin
      @(negedge clk);
      if (done_w[0]) pulses++;
    end
    req = 1'b0;
    n_chk++;
    if (pulses !== 4) begin
      n_fail++;
      $display("FAIL b2b_pulses got=%0d exp=4", pulses);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_error();
    issue(RGGEN_READ,  8'h40, 32'h0, 4'h0, 3'b111);
    issue(RGGEN_WRITE, 8'h40, 32'h1234_5678, 4'hF, 3'b111);
    issue(RGGEN_READ,  8'hFC, 32'h0, 4'h0, 3'b111);
    for (int w = 0; w < 16; w++)
      issue(RGGEN_READ, 8'(w * 4), 32'h0, 4'h0, 3'b111);
  endtask

  task automatic test_reset_abort();
    issue(RGGEN_WRITE, 8'h08, 32'h0000_0001, 4'hF, 3'b111);
    @(negedge clk);
    req = 1'b1; addr = 8'h08; dir = RGGEN_WRITE;
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; en = 3'b100;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    n_chk++;
    if (done_w[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done got=%b exp=0", done_w[2]);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    issue(RGGEN_READ,  8'h08, 32'h0, 4'h0, 3'b111);
    issue(RGGEN_WRITE, 8'h08, 32'h7777_0000, 4'hC, 3'b111);
    issue(RGGEN_READ,  8'h08, 32'h0, 4'h0, 3'b111);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_back_to_back();
    test_error();
    test_reset_abort();
    repeat (8) @(negedge clk);
    n_chk++;
    if (sbq.size() !== 0) begin
      n_fail++;
      $display("FAIL missing_done got=%0d pending exp=0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
